ss_division_eval: RTL and testbench

- Parametrised, self-timed stochastic-symbol (SS) division evaluator.
- On a start pulse it runs an optional warm-up period, then a fixed window of 2^LOG_LEN cycles.
- Each cycle it converts x/y to SS symbols, updates an internal quotient estimate by feedback, and accumulates the quotient symbol into a result counter.
- Ends with busy/done handshake and a held result; sits between the random-number sources and the result readout.

---
 rtl/ss_division_eval.sv | 163 ++++++++++++++++
 tb/tb_ss_division_eval.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ss_division_eval.sv
// Stochastic-symbol division evaluator.
// Feedback-driven quotient estimate accumulated over a fixed window.
module ss_division_eval #(
    parameter int SW      = 2,
    parameter int RW      = 8,
    parameter int IW      = SW + RW - 1,
    parameter int LOG_LEN = 8,
    parameter int WARMUP  = 16,
    parameter int STEP_SH = 0,
    parameter int Q_INIT  = 2 ** RW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [IW-1:0]           x_input,
    input  logic [IW-1:0]           y_input,
    input  logic [RW-1:0]           x_randnum,
    input  logic [RW-1:0]           y_randnum,
    input  logic [RW-1:0]           z_randnum,
    output logic                    busy,
    output logic                    done,
    output logic [SW-1:0]           z_ss,
    output logic [LOG_LEN+SW-1:0]   counter
);

    localparam int PW   = LOG_LEN + $clog2(WARMUP + 2) + 1;
    localparam int DW   = 2 * SW + STEP_SH + 2;
    localparam int SUMW = ((IW > DW) ? IW : DW) + 2;
    localparam int CW   = LOG_LEN + SW;

    localparam logic [PW-1:0] WARM_LAST = PW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [PW-1:0] RUN_LAST  = PW'((2 ** LOG_LEN) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARM,
        S_RUN
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_q;
    logic [PW-1:0]   r_phase;
    logic            r_done;
    logic [CW-1:0]   r_cnt;

    logic [SW-1:0]          w_x_ss;
    logic [SW-1:0]          w_y_ss;
    logic [SW-1:0]          w_zq;
    logic                   w_active;
    logic [2*SW-1:0]        w_prod;
    logic signed [DW-1:0]   w_d;
    logic signed [SUMW-1:0] w_step;
    logic signed [SUMW-1:0] w_sum;
    logic [IW-1:0]          w_qn;
    logic                   w_warm_last;
    logic                   w_run_last;

    // Integer part plus one stochastic LSB from the fractional compare.
    function automatic logic [SW-1:0] f_sym(
        input logic [IW-1:0] v,
        input logic [RW-1:0] r
    );
        logic [SW-1:0] hi;
        hi = SW'(v[IW-1:RW]);
        return hi + SW'(v[RW-1:0] > r);
    endfunction

    // Symbols, feedback error and clamped next estimate.
    always_comb begin
        w_x_ss   = f_sym(x_input, x_randnum);
        w_y_ss   = f_sym(y_input, y_randnum);
        w_zq     = f_sym(r_q, z_randnum);
        w_active = (r_state != S_IDLE);
        z_ss     = w_active ? w_zq : '0;
        w_prod   = (2*SW)'(z_ss) * (2*SW)'(w_y_ss);
        w_d      = $signed(DW'(w_x_ss)) - $signed(DW'(w_prod));
        w_step   = SUMW'(w_d) <<< STEP_SH;
        w_sum    = $signed(SUMW'(r_q)) + w_step;
        if (w_sum[SUMW-1]) begin
            w_qn = '0;
        end else if (|w_sum[SUMW-2:IW]) begin
            w_qn = '1;
        end else begin
            w_qn = w_sum[IW-1:0];
        end
        w_warm_last = (r_phase == WARM_LAST);
        w_run_last  = (r_phase == RUN_LAST);
    end

    // Next-state logic: IDLE -> (WARM) -> RUN -> IDLE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (WARMUP == 0) ? S_RUN : S_WARM;
                end
            end
            S_WARM: begin
                if (w_warm_last) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_run_last) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Estimate, phase counter, accumulator and done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q     <= IW'(Q_INIT);
            r_phase <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_q     <= IW'(Q_INIT);
                        r_cnt   <= '0;
                        r_phase <= '0;
                    end
                end
                S_WARM: begin
                    r_q     <= w_qn;
                    r_phase <= w_warm_last ? '0 : r_phase + PW'(1);
                end
                S_RUN: begin
                    r_q     <= w_qn;
                    r_cnt   <= r_cnt + CW'(z_ss);
                    r_phase <= r_phase + PW'(1);
                    if (w_run_last) begin
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_phase <= '0;
                end
            endcase
        end
    end

    assign busy    = w_active;
    assign done    = r_done;
    assign counter = r_cnt;

endmodule

// File: tb/tb_ss_division_eval.sv
// Directed bench for ss_division_eval.
// Three instances: no warm-up, default warm-up, saturated initial estimate.
module tb_ss_division_eval;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  st = '0;
    logic [8:0]  x_in = '0;
    logic [8:0]  y_in = '0;
    logic [7:0]  xr = '0;
    logic [7:0]  yr = '0;
    logic [7:0]  zr = '0;

    logic [2:0]  w_busy;
    logic [2:0]  w_done;
    logic [1:0]  w_z   [3];
    logic [9:0]  w_cnt [3];

    int          sel = 0;
    logic        o_busy;
    logic        o_done;
    logic [1:0]  o_z;
    logic [9:0]  o_cnt;

    int          n_vec = 0;
    int          n_bad = 0;
    int          d_at;
    int          b_n;
    int          d_n;
    int          z1_n;

    always #5 clk = ~clk;

    ss_division_eval #(.WARMUP(0)) u0 (
        .clk(clk), .rst(rst), .start(st[0]),
        .x_input(x_in), .y_input(y_in),
        .x_randnum(xr), .y_randnum(yr), .z_randnum(zr),
        .busy(w_busy[0]), .done(w_done[0]),
        .z_ss(w_z[0]), .counter(w_cnt[0])
    );

    ss_division_eval u1 (
        .clk(clk), .rst(rst), .start(st[1]),
        .x_input(x_in), .y_input(y_in),
        .x_randnum(xr), .y_randnum(yr), .z_randnum(zr),
        .busy(w_busy[1]), .done(w_done[1]),
        .z_ss(w_z[1]), .counter(w_cnt[1])
    );

    ss_division_eval #(.WARMUP(0), .Q_INIT(511)) u2 (
        .clk(clk), .rst(rst), .start(st[2]),
        .x_input(x_in), .y_input(y_in),
        .x_randnum(xr), .y_randnum(yr), .z_randnum(zr),
        .busy(w_busy[2]), .done(w_done[2]),
        .z_ss(w_z[2]), .counter(w_cnt[2])
    );

    // Route the instance under test to the observation signals.
    always_comb begin
        o_busy = w_busy[sel];
        o_done = w_done[sel];
        o_z    = w_z[sel];
        o_cnt  = w_cnt[sel];
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called #1 after a posedge; leaves us #1 after the accepting edge.
    task automatic pulse_start(input int idx);
        st[idx] = 1'b1;
        @(posedge clk);
        #1;
        st[idx] = 1'b0;
    endtask

    // Sample once per cycle from the accept edge; stop tail cycles after done.
    task automatic observe(
        input  int idx,
        input  int max,
        input  int poke,
        input  int tail,
        output int done_at,
        output int busy_n,
        output int done_n,
        output int zone_n
    );
        done_at = -1;
        busy_n  = 0;
        done_n  = 0;
        zone_n  = 0;
        for (int k = 0; k < max; k++) begin
            if (o_busy) begin
                busy_n++;
                if (o_z == 2'd1) zone_n++;
            end
            if (o_done) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (done_at >= 0 && k >= done_at + tail) break;
            st[idx] = (k == poke);
            @(posedge clk);
            #1;
        end
        st[idx] = 1'b0;
    endtask

    task automatic stim(input int x, input int y);
        x_in = 9'(x);
        y_in = 9'(y);
        xr   = 8'd255;
        yr   = 8'd255;
        zr   = 8'd255;
    endtask

    initial begin
        // Reset state
        sel = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cnt", int'(o_cnt), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_z", int'(o_z), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Unity quotient, no warm-up
        stim(256, 256);
        pulse_start(0);
        observe(0, 400, -1, 3, d_at, b_n, d_n, z1_n);
        chk("t1_done_at", d_at, 256);
        chk("t1_busy_n", b_n, 256);
        chk("t1_done_n", d_n, 1);
        chk("t1_z_ones", z1_n, 256);
        chk("t1_cnt_held", int'(o_cnt), 256);

        // Zero dividend: one step down then hold
        stim(0, 256);
        pulse_start(0);
        observe(0, 400, -1, 0, d_at, b_n, d_n, z1_n);
        chk("t2_done_at", d_at, 256);
        chk("t2_z_ones", z1_n, 1);
        chk("t2_cnt", int'(o_cnt), 1);

        // Upper clamp from 511
        sel = 2;
        stim(256, 0);
        pulse_start(2);
        observe(2, 400, -1, 0, d_at, b_n, d_n, z1_n);
        chk("t3_done_at", d_at, 256);
        chk("t3_z_ones", z1_n, 256);
        chk("t3_cnt", int'(o_cnt), 256);

        // Warm-up with an ignored start at cycle 100
        sel = 1;
        stim(256, 256);
        pulse_start(1);
        observe(1, 400, 100, 3, d_at, b_n, d_n, z1_n);
        chk("t4_done_at", d_at, 272);
        chk("t4_busy_n", b_n, 272);
        chk("t4_done_n", d_n, 1);
        chk("t4_cnt", int'(o_cnt), 256);

        // Reset mid-run
        sel = 0;
        pulse_start(0);
        observe(0, 50, -1, 0, d_at, b_n, d_n, z1_n);
        chk("t5_cnt_mid", int'(o_cnt), 50);
        chk("t5_no_done", d_n, 0);
        rst = 1'b0;
        #1;
        chk("t5_rst_cnt", int'(o_cnt), 0);
        chk("t5_rst_busy", int'(o_busy), 0);
        chk("t5_rst_done", int'(o_done), 0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        pulse_start(0);
        observe(0, 400, -1, 0, d_at, b_n, d_n, z1_n);
        chk("t5_rerun_at", d_at, 256);
        chk("t5_rerun_cnt", int'(o_cnt), 256);

        // Back-to-back: start in the done cycle
        pulse_start(0);
        observe(0, 400, -1, 0, d_at, b_n, d_n, z1_n);
        chk("t6_first_at", d_at, 256);
        pulse_start(0);
        chk("t6_cnt_clr", int'(o_cnt), 0);
        chk("t6_busy", int'(o_busy), 1);
        observe(0, 400, -1, 0, d_at, b_n, d_n, z1_n);
        chk("t6_second_at", d_at, 256);
        chk("t6_cnt", int'(o_cnt), 256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
